// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a registered-read
// byte-addressed RAM. Each access moves one DATA_W word (8 bytes).
//
// Optional build macro MEM_ARB_ALIGN_CHECK_EN: when defined, requests that are
// not 8-byte aligned or that run past MEM_DEPTH are rejected without touching
// the RAM (ack + err pulse). When undefined, every address goes to the RAM and
// err is constant 0.
module mem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_cs,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state;

  // Transaction context latched at grant. ram_addr / ram_wdata double as the
  // latched address and write data: they are loaded once at grant and held.
  logic we_l;
  logic port_l;
  logic last_grant;

  // Registered strobes; gated by rst at the port so a reset cycle never
  // reaches the RAM.
  logic cs_q;
  logic rd_q;
  logic wr_q;

  // Round-robin winner selection and mux of the winner's request fields.
  logic              win_port;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Pick the winner: on a tie the port not granted last wins.
  always_comb begin
    win_port = 1'b0;
    if (req0 && req1) win_port = ~last_grant;
    else if (req1)    win_port = 1'b1;
    win_we    = win_port ? we1    : we0;
    win_addr  = win_port ? addr1  : addr0;
    win_wdata = win_port ? wdata1 : wdata0;
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic [ADDR_W:0] last_byte;
  logic            bad_addr;
  logic            err_q;

  // Reject misaligned words and words whose last byte falls outside the RAM.
  always_comb begin
    last_byte = {1'b0, win_addr} + (ADDR_W+1)'(7);
    bad_addr  = (win_addr[2:0] != 3'b000) || (32'(last_byte) >= MEM_DEPTH);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Main FSM: sequencing, strobes, ack/err pulses and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_l       <= 1'b0;
      port_l     <= 1'b0;
      last_grant <= 1'b1;
      cs_q       <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rdata      <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      // Pulses and strobes default low; each state raises what it needs.
      cs_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            port_l     <= win_port;
            last_grant <= win_port;
            we_l       <= win_we;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            if (bad_addr) begin
              // Rejected: answer straight away, RAM untouched.
              state <= RESP;
              ack0  <= ~win_port;
              ack1  <= win_port;
              err_q <= 1'b1;
            end else begin
              state     <= ISSUE;
              cs_q      <= 1'b1;
              rd_q      <= ~win_we;
              wr_q      <= win_we;
              ram_addr  <= win_addr;
              ram_wdata <= win_wdata;
            end
`else
            state     <= ISSUE;
            cs_q      <= 1'b1;
            rd_q      <= ~win_we;
            wr_q      <= win_we;
            ram_addr  <= win_addr;
            ram_wdata <= win_wdata;
`endif
          end
        end
        ISSUE: begin
          // Writes complete on the strobe edge; reads need one more cycle
          // because the RAM registers its data on that edge.
          if (we_l) begin
            state <= RESP;
            ack0  <= ~port_l;
            ack1  <= port_l;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rdata <= ram_rdata;
          state <= RESP;
          ack0  <= ~port_l;
          ack1  <= port_l;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign ram_cs    = cs_q & ~rst;
  assign ram_read  = rd_q & ~rst;
  assign ram_write = wr_q & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-addressed RAM model, table of single accesses,
// then hand-written contention and mid-read reset sequences.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err, busy;
  logic [DW-1:0] rdata;
  logic          ram_cs, ram_read, ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_init = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(512)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
    .ram_cs(ram_cs), .ram_read(ram_read), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Byte RAM covering the whole address space, little-endian words,
  // read data registered on the strobe edge.
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[16] <= 8'd20;
      mem[3]  <= 8'h5A;
      mem[4]  <= 8'h11;
    end else if (ram_cs) begin
      for (int i = 0; i < 8; i++) begin
        if (ram_write) mem[(int'(ram_addr) + i) & 1023] <= ram_wdata[8*i +: 8];
        if (ram_read)  ram_rdata[8*i +: 8] <= mem[(int'(ram_addr) + i) & 1023];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            exp_lat;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  // One access from a single port; waits (bounded) for that port's ack.
  task automatic run_access(input vec_t v, output int lat, output logic e,
                            output logic [DW-1:0] rd, output int nrd,
                            output int nwr, output int stray);
    @(negedge clk);
    if (v.port == 1'b0) begin req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
    else                begin req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
    lat = 0; e = 1'b0; rd = '0; nrd = 0; nwr = 0; stray = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ram_cs && ram_read)  nrd++;
      if (ram_cs && ram_write) nwr++;
      if (v.port ? ack0 : ack1) stray++;
      if (v.port ? ack1 : ack0) begin
        lat = c; e = err; rd = rdata;
        break;
      end
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin
    int lat, nrd, nwr, stray, lat0, lat1;
    logic e, got0, got1;
    logic [DW-1:0] rd, r0, r1;

    // Table: port, we, addr, wdata, latency, err, rdata after the ack.
    vecs[0] = '{1'b0, 1'b0, 10'd16,  64'h0,                  3, 1'b0, 64'h14};
    vecs[1] = '{1'b1, 1'b1, 10'd32,  64'h0123456789ABCDEF,   2, 1'b0, 64'h14};
    vecs[2] = '{1'b1, 1'b0, 10'd32,  64'h0,                  3, 1'b0, 64'h0123456789ABCDEF};
`ifdef MEM_ARB_ALIGN_CHECK_EN
    vecs[3] = '{1'b0, 1'b0, 10'd3,   64'h0,                  1, 1'b1, 64'h0123456789ABCDEF};
    vecs[4] = '{1'b0, 1'b1, 10'd504, 64'hCAFE,               2, 1'b0, 64'h0123456789ABCDEF};
    vecs[5] = '{1'b1, 1'b1, 10'd508, 64'hDEADBEEF,           1, 1'b1, 64'h0123456789ABCDEF};
    vecs[6] = '{1'b1, 1'b0, 10'd504, 64'h0,                  3, 1'b0, 64'hCAFE};
    vecs[7] = '{1'b0, 1'b0, 10'd508, 64'h0,                  1, 1'b1, 64'hCAFE};
`else
    vecs[3] = '{1'b0, 1'b0, 10'd3,   64'h0,                  3, 1'b0, 64'h115A};
    vecs[4] = '{1'b0, 1'b1, 10'd504, 64'hCAFE,               2, 1'b0, 64'h115A};
    vecs[5] = '{1'b1, 1'b1, 10'd508, 64'hDEADBEEF,           2, 1'b0, 64'h115A};
    vecs[6] = '{1'b1, 1'b0, 10'd504, 64'h0,                  3, 1'b0, 64'hDEADBEEF0000CAFE};
    vecs[7] = '{1'b0, 1'b0, 10'd508, 64'h0,                  3, 1'b0, 64'h00000000DEADBEEF};
`endif

    // Reset and RAM preload.
    ram_init = 1;
    repeat (3) @(negedge clk);
    ram_init = 0;
    rst = 0;
    chk("rst_busy",  busy,      0);
    chk("rst_ack0",  ack0,      0);
    chk("rst_ack1",  ack1,      0);
    chk("rst_err",   err,       0);
    chk("rst_cs",    ram_cs,    0);
    chk("rst_rd",    ram_read,  0);
    chk("rst_wr",    ram_write, 0);
    chk("rst_addr",  ram_addr,  0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_rdata", rdata,     0);

    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i], lat, e, rd, nrd, nwr, stray);
      chk($sformatf("v%0d_lat", i),   lat,   vecs[i].exp_lat);
      chk($sformatf("v%0d_err", i),   e,     vecs[i].exp_err);
      chk($sformatf("v%0d_rdata", i), rd,    vecs[i].exp_rdata);
      chk($sformatf("v%0d_nrd", i),   nrd,   (!vecs[i].exp_err && !vecs[i].we) ? 1 : 0);
      chk($sformatf("v%0d_nwr", i),   nwr,   (!vecs[i].exp_err &&  vecs[i].we) ? 1 : 0);
      chk($sformatf("v%0d_stray", i), stray, 0);
    end

    // Contention right after a fresh reset, done twice.
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      req0 = 1; we0 = 0; addr0 = 10'd16;
      req1 = 1; we1 = 0; addr1 = 10'd32;
      got0 = 0; got1 = 0; lat0 = 0; lat1 = 0; r0 = '0; r1 = '0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (ack0) begin lat0 = c; r0 = rdata; got0 = 1; req0 = 0; end
        if (ack1) begin lat1 = c; r1 = rdata; got1 = 1; req1 = 0; end
        if (got0 && got1) break;
      end
      req0 = 0; req1 = 0;
      chk($sformatf("cont%0d_lat0", rep), lat0, 3);
      chk($sformatf("cont%0d_lat1", rep), lat1, 7);
      chk($sformatf("cont%0d_r0", rep),   r0,   64'h14);
      chk($sformatf("cont%0d_r1", rep),   r1,   64'h0123456789ABCDEF);
    end

    // Reset while a read sits in CAPTURE.
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 10'd16;
    @(negedge clk);
    chk("mid_issue_rd", ram_read, 1);
    @(negedge clk);
    chk("mid_capture_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0; req0 = 0;
    chk("mid_busy",  busy,  0);
    chk("mid_rdata", rdata, 0);
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      if (ack0 || ack1 || err) stray++;
      @(negedge clk);
    end
    chk("mid_no_ack", stray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
